// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus transaction engine.
// State encoding, default phase length and idle strobe levels.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_STB = 3'd1,
        ST_ADDR_REC = 3'd2,
        ST_DATA_STB = 3'd3,
        ST_DATA_REC = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int T_PHASE_DEFAULT = 4;

    localparam logic IDLE_CS_N   = 1'b1;
    localparam logic IDLE_RD_N   = 1'b1;
    localparam logic IDLE_WR_N   = 1'b1;
    localparam logic IDLE_AD_SEL = 1'b1;

    // Phases whose length is set by the phase timer.
    function automatic logic is_timed(input state_t s);
        return (s == ST_ADDR_STB) || (s == ST_ADDR_REC) ||
               (s == ST_DATA_STB) || (s == ST_DATA_REC);
    endfunction

endpackage

// File: rtl/rtc_bus_transaction_timer.sv
// Phase timer: counts cycles within a bus phase and flags the last one.
// Cleared on every state change; counts only while enabled.
module rtc_phase_timer #(
    parameter int T_PHASE = 4,
    localparam int CNT_W  = $clog2(T_PHASE + 1)
) (
    input  logic             clk,
    input  logic             reset_count,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_phase_end
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase_end = i_enable && (r_cnt == i_term);

endmodule

// File: rtl/rtc_bus_transaction.sv
// One read/write access on the RTC multiplexed A/D bus per request from the control FSM.
// Optional macro RTC_BUS_ABORT_EN: dropping the request mid-transaction aborts to IDLE.
module rtc_bus_transaction
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_count,
    input  logic       in_en_funcion,
    input  logic       in_funcion_w_r,
    input  logic [7:0] in_addr,
    input  logic [7:0] in_dato_wr,
    input  logic [7:0] in_ad_bus,
    output logic [7:0] out_ad_bus,
    output logic       out_ad_oe,
    output logic       out_cs_n,
    output logic       out_rd_n,
    output logic       out_wr_n,
    output logic       out_ad_sel,
    output logic       out_flag_done,
    output logic [7:0] out_dato_leido,
    output logic [2:0] out_state
);

    localparam int              CNT_W = $clog2(T_PHASE + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(T_PHASE - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_wr;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    logic       w_timed;
    logic       w_clear;
    logic       w_phase_end;
    logic       w_capture;
    logic [7:0] w_addr;

    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_ad_sel;
    logic       w_oe;
    logic       w_done;
    logic [7:0] w_bus;

    assign w_timed = is_timed(r_state);
    assign w_clear = (w_next != r_state);
    // The address phase starts on the request edge, before the latch is loaded.
    assign w_addr  = (r_state == ST_IDLE) ? in_addr : r_addr;
    assign w_capture = (r_state == ST_DATA_STB) && (w_next == ST_DATA_REC) && !r_wr;

    rtc_phase_timer #(
        .T_PHASE     (T_PHASE)
    ) u_timer (
        .clk         (clk),
        .reset_count (reset_count),
        .i_clear     (w_clear),
        .i_enable    (w_timed),
        .i_term      (TERM),
        .o_phase_end (w_phase_end)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (in_en_funcion) w_next = ST_ADDR_STB;
            ST_ADDR_STB: if (w_phase_end)   w_next = ST_ADDR_REC;
            ST_ADDR_REC: if (w_phase_end)   w_next = ST_DATA_STB;
            ST_DATA_STB: if (w_phase_end)   w_next = ST_DATA_REC;
            ST_DATA_REC: if (w_phase_end)   w_next = ST_DONE;
            ST_DONE:                        w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
`ifdef RTC_BUS_ABORT_EN
        if (w_timed && !in_en_funcion) w_next = ST_IDLE;
`endif

        // Outputs are registered, so they are decoded from the state being entered.
        w_cs_n   = IDLE_CS_N;
        w_rd_n   = IDLE_RD_N;
        w_wr_n   = IDLE_WR_N;
        w_ad_sel = IDLE_AD_SEL;
        w_oe     = 1'b0;
        w_bus    = 8'h00;
        w_done   = 1'b0;
        case (w_next)
            ST_ADDR_STB: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                w_bus  = w_addr;
                w_wr_n = 1'b0;
            end
            ST_ADDR_REC: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                w_bus  = w_addr;
            end
            ST_DATA_STB: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b0;
                if (r_wr) begin
                    w_oe   = 1'b1;
                    w_bus  = r_data;
                    w_wr_n = 1'b0;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            ST_DATA_REC: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b0;
                if (r_wr) begin
                    w_oe  = 1'b1;
                    w_bus = r_data;
                end
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_state        <= ST_IDLE;
            out_cs_n       <= IDLE_CS_N;
            out_rd_n       <= IDLE_RD_N;
            out_wr_n       <= IDLE_WR_N;
            out_ad_sel     <= IDLE_AD_SEL;
            out_ad_oe      <= 1'b0;
            out_ad_bus     <= 8'h00;
            out_flag_done  <= 1'b0;
            out_dato_leido <= 8'h00;
        end else begin
            r_state        <= w_next;
            out_cs_n       <= w_cs_n;
            out_rd_n       <= w_rd_n;
            out_wr_n       <= w_wr_n;
            out_ad_sel     <= w_ad_sel;
            out_ad_oe      <= w_oe;
            out_ad_bus     <= w_bus;
            out_flag_done  <= w_done;
            if (w_capture) out_dato_leido <= in_ad_bus;
        end
    end

    // Request parameters are frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_en_funcion) begin
            r_addr <= in_addr;
            r_data <= in_dato_wr;
            r_wr   <= in_funcion_w_r;
        end
    end

    assign out_state = r_state;

endmodule
